// File: rtl/avmm_gpio_pio.sv
// Avalon-MM general-purpose I/O: synchronised and debounced inputs with
// per-bit edge capture and a masked level interrupt, plus an output register
// with atomic set/clear aliases. Single clock domain, async active-low reset.
module avmm_gpio_pio #(
  parameter int                   IN_WIDTH        = 8,
  parameter int                   OUT_WIDTH       = 8,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   EDGE_MODE       = 0,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in_export,
  output logic [OUT_WIDTH-1:0] pio_out_export
);

  logic [IN_WIDTH-1:0]  sync_meta;
  logic [IN_WIDTH-1:0]  sync;
  logic [IN_WIDTH-1:0]  stable;
  logic [IN_WIDTH-1:0]  stable_d;
  logic [IN_WIDTH-1:0]  edge_hit;
  logic [IN_WIDTH-1:0]  edge_capture;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  cap_clear;
  logic [OUT_WIDTH-1:0] out_reg;
  logic [31:0]          rd_word;
  logic                 wr_out;
  logic                 wr_mask;
  logic                 wr_cap;
  logic                 wr_set;
  logic                 wr_clr;
  logic                 wdata_unused;

  // Upper write-data bits are not stored when the port widths are narrow.
  assign wdata_unused = ^avs_writedata;

  assign wr_out  = avs_write && (avs_address == 3'd1);
  assign wr_mask = avs_write && (avs_address == 3'd2);
  assign wr_cap  = avs_write && (avs_address == 3'd3);
  assign wr_set  = avs_write && (avs_address == 3'd4);
  assign wr_clr  = avs_write && (avs_address == 3'd5);

  // Two-flop synchroniser for the asynchronous input pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= pio_in_export;
      sync      <= sync_meta;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // Debounce bypassed: stable simply follows the synchronised input.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) stable <= '0;
      else                stable <= sync;
    end
  end else begin : g_debounce
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [IN_WIDTH];

    // Per-bit mismatch counter; a change is accepted once it has persisted
    // for DEBOUNCE_CYCLES consecutive cycles, any return to stable restarts it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        stable <= '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
          if (sync[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Previous stable value, used for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) stable_d <= '0;
    else                stable_d <= stable;
  end

  // Edge qualification selected by EDGE_MODE.
  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      0:       edge_hit = stable & ~stable_d;
      1:       edge_hit = ~stable & stable_d;
      default: edge_hit = stable ^ stable_d;
    endcase
  end

  assign cap_clear = wr_cap ? avs_writedata[IN_WIDTH-1:0] : '0;

  // Edge capture with write-1-to-clear; a new edge in the same cycle wins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) edge_capture <= '0;
    else                edge_capture <= (edge_capture & ~cap_clear) | edge_hit;
  end

  // Interrupt mask register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  irq_mask <= '0;
    else if (wr_mask)    irq_mask <= avs_writedata[IN_WIDTH-1:0];
  end

  // Registered level interrupt from pending, unmasked capture bits.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq <= 1'b0;
    else                irq <= |(edge_capture & irq_mask);
  end

  // Output register with direct, set and clear write aliases.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) out_reg <= OUT_RESET;
    else if (wr_out)    out_reg <= avs_writedata[OUT_WIDTH-1:0];
    else if (wr_set)    out_reg <= out_reg | avs_writedata[OUT_WIDTH-1:0];
    else if (wr_clr)    out_reg <= out_reg & ~avs_writedata[OUT_WIDTH-1:0];
  end

  assign pio_out_export = out_reg;

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_word = '0;
    case (avs_address)
      3'd0: rd_word[IN_WIDTH-1:0]  = stable;
      3'd1: rd_word[OUT_WIDTH-1:0] = out_reg;
      3'd2: rd_word[IN_WIDTH-1:0]  = irq_mask;
      3'd3: rd_word[IN_WIDTH-1:0]  = edge_capture;
      3'd6: begin
        rd_word[5:0]   = 6'(IN_WIDTH);
        rd_word[13:8]  = 6'(OUT_WIDTH);
        rd_word[17:16] = 2'(EDGE_MODE);
      end
      default: ;
    endcase
  end

  // Read data register: latency 1, held until the next read.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read)  avs_readdata <= rd_word;
  end

endmodule

// File: tb/tb_avmm_gpio_pio.sv
// Bench for avmm_gpio_pio: instance A (debounce 4, rising edges, reset A5)
// is tracked cycle by cycle by a behavioural model; instance B (no debounce,
// both edges) is exercised with directed steps and fixed expectations.
module tb_avmm_gpio_pio;

  localparam int A_DEB = 4;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [7:0]  pins_a = '0, pins_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [7:0]  pio_out_a, pio_out_b;

  int n_chk = 0;
  int n_fail = 0;

  // Model state for instance A
  logic [7:0]  m_s1, m_s2, m_stable, m_prev, m_cap, m_mask, m_out;
  logic [31:0] m_rdata;
  logic        m_irq;
  int          m_run [8];

  always #5 clk = ~clk;

  avmm_gpio_pio #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(A_DEB), .EDGE_MODE(0), .OUT_RESET(8'hA5)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_a), .avs_address(addr), .avs_read(rd_a),
    .avs_write(wr_a), .avs_writedata(wdata), .avs_readdata(rdata_a), .irq(irq_a),
    .pio_in_export(pins_a), .pio_out_export(pio_out_a)
  );

  avmm_gpio_pio #(
    .IN_WIDTH(8), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .OUT_RESET(8'h00)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_b), .avs_address(addr), .avs_read(rd_b),
    .avs_write(wr_b), .avs_writedata(wdata), .avs_readdata(rdata_b), .irq(irq_b),
    .pio_in_export(pins_b), .pio_out_export(pio_out_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_cap = '0; m_mask = '0;
    m_out = 8'hA5; m_rdata = '0; m_irq = 1'b0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  // One clock of instance A's behaviour, from the values present at the edge.
  task automatic model_a();
    logic [7:0]  st_n, ed, clr;
    logic [31:0] rd;
    if (!rst_a) begin
      m_reset();
    end else begin
      st_n = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == A_DEB) begin
            st_n[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      ed = m_stable & ~m_prev;
      case (addr)
        3'd0:    rd = {24'b0, m_stable};
        3'd1:    rd = {24'b0, m_out};
        3'd2:    rd = {24'b0, m_mask};
        3'd3:    rd = {24'b0, m_cap};
        3'd6:    rd = 32'h0000_0808;
        default: rd = 32'h0;
      endcase
      if (rd_a) m_rdata = rd;
      m_irq = |(m_cap & m_mask);
      clr = (wr_a && addr == 3'd3) ? wdata[7:0] : 8'h00;
      m_cap = (m_cap & ~clr) | ed;
      if (wr_a) begin
        case (addr)
          3'd1: m_out = wdata[7:0];
          3'd2: m_mask = wdata[7:0];
          3'd4: m_out = m_out | wdata[7:0];
          3'd5: m_out = m_out & ~wdata[7:0];
          default: ;
        endcase
      end
      m_prev = m_stable;
      m_stable = st_n;
      m_s2 = m_s1;
      m_s1 = pins_a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_a();
    #1;
    chk("a_pio_out", {24'b0, pio_out_a}, {24'b0, m_out});
    chk("a_irq", {31'b0, irq_a}, {31'b0, m_irq});
    chk("a_readdata", rdata_a, m_rdata);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_a(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    wr_a = w; rd_a = r; addr = a; wdata = d;
    tick();
    wr_a = 1'b0; rd_a = 1'b0;
  endtask

  task automatic bus_b(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    wr_b = w; rd_b = r; addr = a; wdata = d;
    tick();
    wr_b = 1'b0; rd_b = 1'b0;
  endtask

  initial begin
    m_reset();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out", {24'b0, pio_out_a}, 32'hA5);
    chk("rst_a_irq", {31'b0, irq_a}, 32'h0);
    chk("rst_a_rdata", rdata_a, 32'h0);
    chk("rst_b_out", {24'b0, pio_out_b}, 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // INFO registers
    bus_a(1'b0, 1'b1, 3'd6, 32'h0);
    chk("a_info", rdata_a, 32'h0000_0808);
    bus_b(1'b0, 1'b1, 3'd6, 32'h0);
    chk("b_info", rdata_b, 32'h0002_0808);

    // Glitch of 3 cycles is rejected
    pins_a = 8'h01;
    ticks(3);
    pins_a = 8'h00;
    ticks(8);
    bus_a(1'b0, 1'b1, 3'd0, 32'h0);
    chk("a_glitch_data", rdata_a, 32'h0);
    bus_a(1'b0, 1'b1, 3'd3, 32'h0);
    chk("a_glitch_cap", rdata_a, 32'h0);

    // Held input: stable after exactly 2+4 cycles, capture one cycle later
    pins_a = 8'h01;
    ticks(5);
    bus_a(1'b0, 1'b1, 3'd0, 32'h0);
    chk("a_data_cyc6", rdata_a, 32'h0);
    bus_a(1'b0, 1'b1, 3'd0, 32'h0);
    chk("a_data_cyc7", rdata_a, 32'h1);
    bus_a(1'b0, 1'b1, 3'd3, 32'h0);
    chk("a_cap_set", rdata_a, 32'h1);

    // Interrupt masking and W1C
    bus_a(1'b1, 1'b0, 3'd2, 32'h1);
    chk("a_irq_mask_same", {31'b0, irq_a}, 32'h0);
    tick();
    chk("a_irq_assert", {31'b0, irq_a}, 32'h1);
    bus_a(1'b1, 1'b0, 3'd3, 32'h0);
    tick();
    chk("a_irq_w0_keep", {31'b0, irq_a}, 32'h1);
    bus_a(1'b1, 1'b0, 3'd3, 32'h1);
    chk("a_irq_w1c_same", {31'b0, irq_a}, 32'h1);
    tick();
    chk("a_irq_w1c_clear", {31'b0, irq_a}, 32'h0);

    // Output register and set/clear aliases
    bus_a(1'b1, 1'b0, 3'd1, 32'h0F);
    bus_a(1'b1, 1'b0, 3'd4, 32'h30);
    bus_a(1'b1, 1'b0, 3'd5, 32'h05);
    chk("a_out_setclr", {24'b0, pio_out_a}, 32'h3A);
    bus_a(1'b0, 1'b1, 3'd4, 32'h0);
    chk("a_outset_read", rdata_a, 32'h0);
    bus_a(1'b0, 1'b1, 3'd1, 32'h0);
    chk("a_out_read", rdata_a, 32'h3A);

    // W1C coincident with a new rising edge on bit 2: set wins
    pins_a = 8'h05;
    ticks(10);
    pins_a = 8'h01;
    ticks(10);
    pins_a = 8'h05;
    ticks(6);
    bus_a(1'b1, 1'b0, 3'd3, 32'h04);
    bus_a(1'b0, 1'b1, 3'd3, 32'h0);
    chk("a_w1c_vs_edge", rdata_a, 32'h04);

    // Randomised traffic on A, tracked by the model each cycle
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 11) == 0) pins_a[b] = ~pins_a[b];
      rd_a = 1'($urandom_range(0, 1));
      wr_a = ($urandom_range(0, 2) == 0);
      addr = 3'($urandom_range(0, 7));
      wdata = $urandom;
      tick();
    end
    rd_a = 1'b0;
    wr_a = 1'b0;
    ticks(10);

    // Reset of A mid-operation with pin 0 held high
    pins_a = 8'h01;
    ticks(3);
    rst_a = 1'b0;
    m_reset();
    ticks(2);
    chk("a_midrst_out", {24'b0, pio_out_a}, 32'hA5);
    rst_a = 1'b1;
    ticks(7);
    bus_a(1'b0, 1'b1, 3'd3, 32'h0);
    chk("a_requal_cap", rdata_a, 32'h1);

    // Instance B: both edges, no debounce
    pins_b = 8'h08;
    ticks(4);
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_rise_cap", rdata_b, 32'h08);
    pins_b = 8'h00;
    bus_b(1'b1, 1'b0, 3'd3, 32'h08);
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_cleared", rdata_b, 32'h0);
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_before_fall", rdata_b, 32'h0);
    tick();
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_fall_cap", rdata_b, 32'h08);
    bus_b(1'b1, 1'b0, 3'd2, 32'h08);
    tick();
    chk("b_irq", {31'b0, irq_b}, 32'h1);

    // Asynchronous reset of B in the middle of a pulse
    pins_b = 8'h08;
    ticks(2);
    #2 rst_b = 1'b0;
    #1;
    chk("b_async_irq", {31'b0, irq_b}, 32'h0);
    chk("b_async_rdata", rdata_b, 32'h0);
    chk("b_async_out", {24'b0, pio_out_b}, 32'h0);
    ticks(2);
    rst_b = 1'b1;
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_rst_cap", rdata_b, 32'h0);
    bus_b(1'b0, 1'b1, 3'd2, 32'h0);
    chk("b_rst_mask", rdata_b, 32'h0);
    ticks(2);
    bus_b(1'b0, 1'b1, 3'd3, 32'h0);
    chk("b_requal_cap", rdata_b, 32'h08);
    chk("b_irq_masked", {31'b0, irq_b}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
